// File: rtl/shift_pkg.sv
// Shared definitions for the shifter-operand sequencer: FSM states, Rs amount
// width and the shifter's shift_control encodings.
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RS_WAIT = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int AMT_REG_BITS = 8;

  // shift_control encodings understood by the shifter_rotater; the sequencer
  // passes these through untouched.
  localparam logic [2:0] SH_LSL = 3'b000;
  localparam logic [2:0] SH_LSR = 3'b001;
  localparam logic [2:0] SH_ASR = 3'b010;
  localparam logic [2:0] SH_ROR = 3'b011;

endpackage

// File: rtl/shift_sequencer.sv
// Execute-stage sequencer for ARM shifter operands: latches a request, fetches
// Rs when the amount is register-specified, fires the shifter once, holds the result.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no operation in flight, ready for a request
// ST_RS_WAIT | waiting on the Rs read port for the shift amount
// ST_SHIFT   | shifter enabled this cycle, result captured at its end
// ST_DONE    | result held on res_* until downstream accepts it
module shift_sequencer #(
  parameter int DATA_W     = 32,
  parameter int RS_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic [2:0]        req_ctrl,
  input  logic [4:0]        req_imm,
  input  logic              req_reg_shift,
  input  logic [3:0]        req_rs_idx,
  input  logic              req_carry,
  output logic              rs_rd_en,
  output logic [3:0]        rs_rd_idx,
  input  logic [31:0]       rs_rd_data,
  input  logic              rs_rd_valid,
  output logic [DATA_W-1:0] sh_in_data,
  output logic [31:0]       sh_amt_reg,
  output logic [2:0]        sh_control,
  output logic [4:0]        sh_amt_imm,
  output logic              sh_enable,
  output logic              sh_carry_in,
  input  logic [DATA_W-1:0] sh_out_data,
  input  logic              sh_carry_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry,
  output logic              res_err
);
  import shift_pkg::*;

  localparam int CNT_W = $clog2(RS_TIMEOUT + 1);

  state_t state, state_nxt;

  logic [DATA_W-1:0]       op_data;
  logic [2:0]              op_ctrl;
  logic [4:0]              op_imm;
  logic [3:0]              op_rs_idx;
  logic                    op_carry;
  logic [AMT_REG_BITS-1:0] amt_reg;
  logic [CNT_W-1:0]        wait_cnt;
  logic [DATA_W-1:0]       res_data_q;
  logic                    res_carry_q;
  logic                    err_q;

  logic accept;
  logic rs_hit;
  logic rs_zero;
  logic timeout;
  logic unused_rs_hi;

  // Only the low byte of Rs carries the amount.
  assign unused_rs_hi = ^rs_rd_data[31:AMT_REG_BITS];

  assign req_ready = !rst && !flush &&
                     (state == ST_IDLE || (state == ST_DONE && res_ready));
  assign accept    = req_valid && req_ready;
  assign rs_hit    = (state == ST_RS_WAIT) && rs_rd_valid && !flush;
  assign rs_zero   = (rs_rd_data[AMT_REG_BITS-1:0] == '0);
  assign timeout   = (state == ST_RS_WAIT) && !rs_rd_valid && !flush &&
                     (wait_cnt == CNT_W'(RS_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    rs_rd_en  = 1'b0;
    sh_enable = 1'b0;
    res_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = req_reg_shift ? ST_RS_WAIT : ST_SHIFT;
      end
      ST_RS_WAIT: begin
        rs_rd_en = 1'b1;
        if (rs_rd_valid)  state_nxt = rs_zero ? ST_DONE : ST_SHIFT;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_SHIFT: begin
        sh_enable = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (accept) state_nxt = req_reg_shift ? ST_RS_WAIT : ST_SHIFT;
          else        state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_data     <= '0;
      op_ctrl     <= '0;
      op_imm      <= '0;
      op_rs_idx   <= '0;
      op_carry    <= 1'b0;
      amt_reg     <= '0;
      wait_cnt    <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state    <= state_nxt;
      err_q    <= timeout;
      wait_cnt <= (state == ST_RS_WAIT && state_nxt == ST_RS_WAIT) ?
                  wait_cnt + CNT_W'(1) : '0;

      if (accept) begin
        op_data   <= req_data;
        op_ctrl   <= req_ctrl;
        // The unused amount source is forced to zero so the shifter sees one.
        op_imm    <= req_reg_shift ? 5'd0 : req_imm;
        op_rs_idx <= req_rs_idx;
        op_carry  <= req_carry;
        amt_reg   <= '0;
      end else if (rs_hit) begin
        amt_reg <= rs_rd_data[AMT_REG_BITS-1:0];
      end

      if (state == ST_SHIFT && !flush) begin
        res_data_q  <= sh_out_data;
        res_carry_q <= sh_carry_out;
      end else if (rs_hit && rs_zero) begin
        res_data_q  <= op_data;
        res_carry_q <= op_carry;
      end
    end
  end

  assign rs_rd_idx   = op_rs_idx;
  assign sh_in_data  = op_data;
  assign sh_amt_reg  = {{(32 - AMT_REG_BITS){1'b0}}, amt_reg};
  assign sh_control  = op_ctrl;
  assign sh_amt_imm  = op_imm;
  assign sh_carry_in = op_carry;
  assign res_data    = res_data_q;
  assign res_carry   = res_carry_q;
  assign res_err     = err_q;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Execute-stage controller that sequences the barrel shifter/rotater for ARM data-processing shifter operands. It accepts one shift request at a time over a valid/ready handshake and selects an immediate or register-specified shift amount. For register-specified shifts it fetches Rs through a dedicated register-file read port. It pulses the shifter's enable for exactly one cycle, captures the result and carry, and holds them until the downstream stage accepts them.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- RS_TIMEOUT, 15, max cycles to wait for an Rs read response

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  abort in-flight operation
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_data  in  DATA_W  Rm operand
- req_ctrl  in  3  shift type, shifter encoding, passed through opaque
- req_imm  in  5  immediate shift amount
- req_reg_shift  in  1  1 = amount from Rs[7:0]
- req_rs_idx  in  4  Rs register index
- req_carry  in  1  current C flag
- rs_rd_en  out  1  Rs read request, held until response
- rs_rd_idx  out  4  Rs index
- rs_rd_data  in  32  Rs value
- rs_rd_valid  in  1  Rs response valid; only meaningful while rs_rd_en=1
- sh_in_data  out  DATA_W  to shifter in_data
- sh_amt_reg  out  32  to shifter shift_amt_reg
- sh_control  out  3  to shifter shift_control
- sh_amt_imm  out  5  to shifter shift_amt_imm
- sh_enable  out  1  to shifter enable
- sh_carry_in  out  1  to shifter carry_flag
- sh_out_data  in  DATA_W  from shifter out_data
- sh_carry_out  in  1  from shifter carry_out_flag
- res_valid  out  1  result held
- res_ready  in  1  downstream accepts
- res_data  out  DATA_W  shifted operand
- res_carry  out  1  shifter carry-out
- res_err  out  1  one-cycle pulse on Rs timeout

## Operation
- States: IDLE, RS_WAIT, SHIFT, DONE.
- req_ready = !flush && (state==IDLE || (state==DONE && res_ready)).
- Accept sequence:
  - Operands (data, ctrl, imm, reg_shift, rs_idx, carry) latch into an operand register.
  - Next state is SHIFT if req_reg_shift=0, else RS_WAIT.
- RS_WAIT:
  - rs_rd_en=1 and rs_rd_idx=latched idx.
  - When rs_rd_valid=1, latch sh_amt_reg = {24'b0, rs_rd_data[7:0]}.
  - If rs_rd_data[7:0]==0, bypass the shifter: go to DONE with res_data=Rm and res_carry=latched carry. sh_enable never asserts.
  - Otherwise go to SHIFT.
  - A cycle counter increments every RS_WAIT cycle. If it reaches RS_TIMEOUT without a response, pulse res_err for one cycle, drop rs_rd_en and return to IDLE with no result.
- SHIFT:
  - sh_enable=1 for exactly this one cycle.
  - sh_out_data and sh_carry_out are sampled at the end of the cycle into res_data/res_carry.
  - Next state is DONE.
- DONE:
  - res_valid=1 and the result is held stable.
  - On res_ready=1: go to IDLE, or directly to SHIFT/RS_WAIT if a new request is accepted in the same cycle.
- Immediate-shift requests leave sh_amt_reg at 0. Register-shift requests leave sh_amt_imm at 0.
- sh_* outputs drive from the operand register in every state. Only sh_enable qualifies them.
- Flush, in any state:
  - Next state is IDLE and res_valid drops.
  - rs_rd_en drops; any late response is ignored.
  - Flush wins over a simultaneous req_valid and over rs_rd_valid.

## Timing
- Reset (rst=1 at an edge): state IDLE; counter 0; all outputs 0 except req_ready, which is 1 from the first cycle after reset deassertion.
- Reset mid-operation discards everything. No res_err is issued.
- Immediate latency: accept edge at cycle 0 → SHIFT in cycle 1 → res_valid in cycle 2.
- Register latency: accept at cycle 0 → RS_WAIT from cycle 1 → response in cycle k → SHIFT in k+1 → res_valid in k+2.
  - Bypass case: res_valid in k+1.
- Back-to-back throughput: with res_ready held high, a new request is accepted in each DONE cycle, giving one result every 2 cycles for immediate shifts.
- res_valid/res_data/res_carry change only at a handshake, a flush or a reset.
- Timeout: res_err pulses in the cycle after the RS_TIMEOUT-th RS_WAIT cycle.

## Structure
- Shared package shift_pkg holds:
  - the state enum;
  - AMT_REG_BITS=8;
  - the shifter shift_control encodings, for benches only (the RTL treats them as opaque).
- Single module. The shifter_rotater instance lives in the execute-stage parent beside this block, wired through the sh_* ports.
- The timeout counter is inline. No sub-module is needed.

## Test plan
- Immediate request: data=0x88888888, ctrl=3'b001, imm=16 → sh_enable is high only in cycle 1 with sh_amt_imm=16; res_valid in cycle 2; res_data/res_carry equal the shifter model output.
- Register request with Rs=0x00000104, response after 3 cycles → sh_amt_reg=0x00000004; sh_enable pulses once; res_valid 2 cycles after the response.
- Register request with Rs=0x00000100 and carry=1 → bypass: res_data=0x88888888, res_carry=1, sh_enable never high.
- Backpressure: hold res_ready=0 for 5 cycles → result stable and req_ready=0; then raise res_ready with a pending request → accepted in the same cycle.
- Flush during RS_WAIT, then a late rs_rd_valid → rs_rd_en drops the next cycle, the response is ignored, state is IDLE and there is no res_valid.
- No Rs response → res_err pulses after 15 RS_WAIT cycles and the block is IDLE afterwards.
